// File: rtl/fdivsqrt_uotfc4_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fdivsqrt_uotfc4_seq
// Description : Sequential radix-4 on-the-fly converter. It keeps U, UM and C
//               and accepts one signed radix-4 digit per iteration.
//               Optional: FDIVSQRT_OTFC_CHECK_EN adds a sticky illegal-digit flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fdivsqrt_uotfc4_seq #(
    parameter int DIVb  = 56,
    parameter int NITER = 28
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             start,
    input  logic                             sqrt_mode,
    input  logic                             flush,
    input  logic                             digit_valid,
    input  logic                             stall,
    input  logic [3:0]                       udigit,
    output logic [DIVb+3:0]                  U,
    output logic [DIVb+3:0]                  UM,
    output logic [DIVb+3:0]                  C,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(NITER+1)-1:0]       iter,
    output logic                             digit_err
);

    localparam int W    = DIVb + 4;
    localparam int c_iw = $clog2(NITER + 1);
    localparam logic [W-1:0] c_c0     = {4'b1111, {DIVb{1'b0}}};
    localparam logic [W-1:0] c_sqrt_u = {3'b000, 1'b1, {DIVb{1'b0}}};
    localparam logic [W-1:0] c_top2   = {2'b11, {(W-2){1'b0}}};
    localparam logic [c_iw-1:0] c_last = c_iw'(NITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_u;
    logic [W-1:0]     r_um;
    logic [W-1:0]     r_c;
    logic [c_iw-1:0]  r_iter;
    logic [W-1:0]     w_cn;
    logic [W-1:0]     w_k;
    logic [W-1:0]     w_k2;
    logic [W-1:0]     w_u_nxt;
    logic [W-1:0]     w_um_nxt;
    logic             w_accept;
    logic             w_load;

    assign w_accept = (r_state == S_BUSY) && digit_valid && !stall && !flush;
    assign w_load   = (r_state == S_IDLE) && start && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_state_nxt = S_BUSY;
                S_BUSY:  if (w_accept && (r_iter == c_last)) w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // K marks the new lower digit bit, K2 the upper one, both just below the old ulp.
    assign w_cn = c_top2 | (r_c >> 2);
    assign w_k  = w_cn & ~(w_cn << 1);
    assign w_k2 = w_k << 1;

    always_comb begin
        w_u_nxt  = r_u;
        w_um_nxt = r_um;
        if (udigit[3]) begin
            w_u_nxt  = r_u | w_k2;
            w_um_nxt = r_u | w_k;
        end else if (udigit[2]) begin
            w_u_nxt  = r_u | w_k;
            w_um_nxt = r_u;
        end else if (udigit[1]) begin
            w_u_nxt  = r_um | w_k2 | w_k;
            w_um_nxt = r_um | w_k2;
        end else if (udigit[0]) begin
            w_u_nxt  = r_um | w_k2;
            w_um_nxt = r_um | w_k;
        end else begin
            w_um_nxt = r_um | w_k2 | w_k;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_u    <= '0;
            r_um   <= '0;
            r_c    <= '0;
            r_iter <= '0;
        end else if (w_load) begin
            r_u    <= sqrt_mode ? c_sqrt_u : '0;
            r_um   <= sqrt_mode ? '0 : c_c0;
            r_c    <= c_c0;
            r_iter <= '0;
        end else if (w_accept) begin
            r_u    <= w_u_nxt;
            r_um   <= w_um_nxt;
            r_c    <= w_cn;
            r_iter <= r_iter + c_iw'(1);
        end
    end

`ifdef FDIVSQRT_OTFC_CHECK_EN
    logic r_digit_err;
    logic w_multi_hot;

    assign w_multi_hot = (udigit & (udigit - 4'd1)) != 4'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_digit_err <= 1'b0;
        end else if (w_load) begin
            r_digit_err <= 1'b0;
        end else if (w_accept && w_multi_hot) begin
            r_digit_err <= 1'b1;
        end
    end

    assign digit_err = r_digit_err;
`else
    assign digit_err = 1'b0;
`endif

    assign U    = r_u;
    assign UM   = r_um;
    assign C    = r_c;
    assign iter = r_iter;
    assign busy = (r_state == S_BUSY);
    assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fdivsqrt_uotfc4_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fdivsqrt_uotfc4_seq
// Description : Randomised scoreboard bench for the radix-4 on-the-fly converter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fdivsqrt_uotfc4_seq;

    localparam int DIVB  = 8;
    localparam int NITER = 4;
    localparam int W     = 12;
    localparam int IW    = 3;
`ifdef FDIVSQRT_OTFC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          sqrt_mode = 1'b0;
    logic          flush = 1'b0;
    logic          digit_valid = 1'b0;
    logic          stall = 1'b0;
    logic [3:0]    udigit = 4'd0;
    logic [W-1:0]  U, UM, C;
    logic          busy, done, digit_err;
    logic [IW-1:0] iter;

    fdivsqrt_uotfc4_seq #(.DIVb(DIVB), .NITER(NITER)) dut (
        .clk(clk), .resetn(resetn), .start(start), .sqrt_mode(sqrt_mode),
        .flush(flush), .digit_valid(digit_valid), .stall(stall), .udigit(udigit),
        .U(U), .UM(UM), .C(C), .busy(busy), .done(done), .iter(iter),
        .digit_err(digit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  u;
        logic [W-1:0]  um;
        logic [W-1:0]  c;
        logic [IW-1:0] it;
        logic          err;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Signed digit value with bit3 > bit2 > bit1 > bit0 priority.
    function automatic int dval(input logic [3:0] d);
        if (d[3]) return 2;
        if (d[2]) return 1;
        if (d[1]) return -1;
        if (d[0]) return -2;
        return 0;
    endfunction

    // Result after n digits: value = init + sum d_i * 4^-i, ulp = 4^-n (scaled by 2^DIVB).
    function automatic exp_t model(input bit sq, input logic [15:0] ds, input int n);
        exp_t   e;
        longint u, ulp, t;
        u = sq ? (longint'(1) << DIVB) : 0;
        e.err = 1'b0;
        for (int i = 0; i < n; i++) begin
            logic [3:0] d;
            d = ds[4*i +: 4];
            u += longint'(dval(d)) * (longint'(1) << (DIVB - 2*(i+1)));
            if (CHK && ($countones(d) > 1)) e.err = 1'b1;
        end
        ulp  = longint'(1) << (DIVB - 2*n);
        e.u  = u[W-1:0];
        t    = u - ulp;
        e.um = t[W-1:0];
        t    = -ulp;
        e.c  = t[W-1:0];
        e.it = IW'(n);
        return e;
    endfunction

    function automatic logic [3:0] rand_digit();
        logic [3:0] tbl [5];
        tbl[0] = 4'b0000; tbl[1] = 4'b0001; tbl[2] = 4'b0010;
        tbl[3] = 4'b0100; tbl[4] = 4'b1000;
        if ($urandom_range(0, 7) == 0) return 4'($urandom);
        return tbl[$urandom_range(0, 4)];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit sq);
        sqrt_mode = sq;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        sqrt_mode = 1'($urandom);
    endtask

    task automatic send(input logic [3:0] d, input bit inj);
        digit_valid = 1'b1;
        stall       = 1'b0;
        udigit      = d;
        start       = inj;
        tick();
        digit_valid = 1'b0;
        start       = 1'b0;
        udigit      = 4'($urandom);
    endtask

    task automatic hold(input int n, input bit inj);
        for (int h = 0; h < n; h++) begin
            digit_valid = 1'($urandom);
            stall       = digit_valid ? 1'b1 : 1'($urandom);
            udigit      = 4'($urandom);
            start       = inj;
            tick();
            start       = 1'b0;
            stall       = 1'b0;
            digit_valid = 1'b0;
        end
    endtask

    task automatic finish_check();
        chk("done_after_last", done, 1'b1);
        chk("busy_in_done", busy, 1'b0);
        stall = 1'($urandom);
        tick();
        stall = 1'b0;
        chk("done_one_cycle", done, 1'b0);
    endtask

    task automatic run_op(input bit sq, input logic [15:0] ds, input int maxgap, input bit inj);
        sbq.push_back(model(sq, ds, NITER));
        do_start(sq);
        chk("start_busy", busy, 1'b1);
        chk("start_c", C, 12'hF00);
        for (int i = 0; i < NITER; i++) begin
            hold((maxgap > 0) ? $urandom_range(0, maxgap) : 0, inj);
            chk("hold_iter", iter, i);
            send(ds[4*i +: 4], inj);
        end
        finish_check();
    endtask

    // Scoreboard monitor: every done pulse consumes one expected result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected_done: got done=1 expected no pending result at %0t", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_U", U, e.u);
                    chk("sb_UM", UM, e.um);
                    chk("sb_C", C, e.c);
                    chk("sb_iter", iter, e.it);
                    chk("sb_err", digit_err, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ds;
        exp_t        e;

        #2;
        chk("rst_U", U, 0);
        chk("rst_UM", UM, 0);
        chk("rst_C", C, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_iter", iter, 0);
        chk("rst_err", digit_err, 0);
        tick();
        resetn = 1'b1;
        tick();

        // Divide +1,+2,0,-1 back-to-back
        ds = {4'b0010, 4'b0000, 4'b1000, 4'b0100};
        sbq.push_back(model(1'b0, ds, NITER));
        do_start(1'b0);
        chk("d1_um0", UM, 12'hF00);
        send(4'b0100, 1'b0); chk("d1_U1", U, 12'h040); chk("d1_UM1", UM, 12'h000);
        send(4'b1000, 1'b0); chk("d1_U2", U, 12'h060); chk("d1_UM2", UM, 12'h050);
        send(4'b0000, 1'b0); chk("d1_U3", U, 12'h060); chk("d1_UM3", UM, 12'h05C);
        send(4'b0010, 1'b0); chk("d1_U4", U, 12'h05F); chk("d1_UM4", UM, 12'h05E);
        chk("d1_C", C, 12'hFFF);
        chk("d1_iter", iter, 4);
        finish_check();

        // Divide, first digit -2
        ds = {rand_digit(), rand_digit(), rand_digit(), 4'b0001};
        sbq.push_back(model(1'b0, ds, NITER));
        do_start(1'b0);
        send(4'b0001, 1'b0);
        chk("neg2_U", U, 12'hF80); chk("neg2_UM", UM, 12'hF40); chk("neg2_C", C, 12'hFC0);
        for (int i = 1; i < NITER; i++) send(ds[4*i +: 4], 1'b0);
        finish_check();

        // Sqrt, first digit 0
        ds = {rand_digit(), rand_digit(), rand_digit(), 4'b0000};
        sbq.push_back(model(1'b1, ds, NITER));
        do_start(1'b1);
        chk("sq_U0", U, 12'h100); chk("sq_UM0", UM, 12'h000);
        send(4'b0000, 1'b0);
        chk("sq_U1", U, 12'h100); chk("sq_UM1", UM, 12'h0C0);
        for (int i = 1; i < NITER; i++) send(ds[4*i +: 4], 1'b0);
        finish_check();

        // Same sequence with stall after 2nd digit and valid gaps
        ds = {4'b0010, 4'b0000, 4'b1000, 4'b0100};
        sbq.push_back(model(1'b0, ds, NITER));
        do_start(1'b0);
        send(4'b0100, 1'b0);
        digit_valid = 1'b0; tick(); chk("gap_iter", iter, 1);
        send(4'b1000, 1'b0);
        for (int h = 0; h < 3; h++) begin
            digit_valid = 1'b1; stall = 1'b1; udigit = 4'b0001;
            tick();
            chk("stall_U", U, 12'h060); chk("stall_done", done, 0);
        end
        stall = 1'b0; digit_valid = 1'b0; tick(); tick();
        chk("gap_UM", UM, 12'h050);
        send(4'b0000, 1'b0);
        send(4'b0010, 1'b0);
        finish_check();

        // Asynchronous reset during 3rd iteration
        do_start(1'b0);
        send(4'b0100, 1'b0);
        send(4'b1000, 1'b0);
        digit_valid = 1'b1; udigit = 4'b0100;
        #2 resetn = 1'b0;
        #1;
        chk("arst_U", U, 0); chk("arst_UM", UM, 0); chk("arst_C", C, 0);
        chk("arst_busy", busy, 0); chk("arst_iter", iter, 0);
        digit_valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        chk("arst_idle", busy, 0);

        // Flush mid-BUSY, then start+flush in IDLE, then a clean reload
        ds = {rand_digit(), rand_digit(), rand_digit(), rand_digit()};
        e = model(1'b0, ds, 2);
        do_start(1'b0);
        send(ds[3:0], 1'b0);
        send(ds[7:4], 1'b0);
        flush = 1'b1; digit_valid = 1'b1; udigit = ds[11:8];
        tick();
        flush = 1'b0; digit_valid = 1'b0;
        chk("fl_busy", busy, 0); chk("fl_done", done, 0);
        chk("fl_U", U, e.u); chk("fl_UM", UM, e.um); chk("fl_C", C, e.c);
        chk("fl_iter", iter, 2);
        tick(); tick();
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("fl_start_busy", busy, 0); chk("fl_start_C", C, e.c);
        run_op(1'b1, {rand_digit(), rand_digit(), rand_digit(), rand_digit()}, 2, 1'b0);

        // Multi-hot digit 0110 decodes as +1
        ds = {4'b0000, 4'b0000, 4'b0000, 4'b0110};
        sbq.push_back(model(1'b0, ds, NITER));
        do_start(1'b0);
        send(4'b0110, 1'b0);
        chk("mh_U", U, 12'h040); chk("mh_err", digit_err, CHK);
        for (int i = 1; i < NITER; i++) send(4'b0000, 1'b0);
        finish_check();
        chk("mh_err_held", digit_err, CHK);
        do_start(1'b0);
        chk("mh_err_clr", digit_err, 0);
        flush = 1'b1; tick(); flush = 1'b0;

        // Randomised operations with gaps, stalls and ignored start pulses
        for (int n = 0; n < 40; n++) begin
            ds = {rand_digit(), rand_digit(), rand_digit(), rand_digit()};
            run_op(1'($urandom), ds, 3, 1'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        tick(); tick();
        chk("sb_drain", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fdivsqrt_uotfc4_seq.md
Name: fdivsqrt_uotfc4_seq

Overview:
Sequential radix-4 on-the-fly converter for the div/sqrt datapath. It consumes one signed radix-4 quotient/root digit per iteration and keeps U (the partial result), UM (U minus one ulp) and C (the position mask) in registers. These registers are the producer of the U/UM/C operands that the radix-4 F addend generator reads. Iteration control (start, count, done) is handled locally, so the block can be unit-tested outside the full divider.

Parameters:
DIVb, 56, fractional result bits; internal width W = DIVb+4
NITER, 28, digits accepted per operation (2 bits/digit); must satisfy 2*NITER <= DIVb

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  begin operation; sampled only in IDLE
sqrt_mode  in  1  1 = sqrt initialisation, 0 = divide; sampled with start
flush  in  1  synchronous abort to IDLE
digit_valid  in  1  udigit valid this cycle
stall  in  1  hold all state; digit not consumed
udigit  in  4  one-hot digit {+2,+1,-1,-2} = bits [3:0]; 0000 = digit 0
U  out  W  partial result
UM  out  W  U minus ulp
C  out  W  position mask (ones at and above current ulp)
busy  out  1  high in BUSY
done  out  1  one-cycle pulse after last digit
iter  out  $clog2(NITER+1)  digits consumed
digit_err  out  1  sticky illegal-digit flag (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk. resetn is asynchronous and active-low.
- Reset values: state=IDLE; U=UM=C=0; busy=0; done=0; iter=0; digit_err=0. resetn asserted mid-operation discards the operation immediately.
- States: IDLE, BUSY, DONE.
- IDLE->BUSY on start. The start cycle loads the following, with C0 = {4'b1111, DIVb'b0}:
  - C=C0; iter=0; digit_err=0.
  - Divide: U=0, UM=C0 (-ulp in two's complement).
  - Sqrt: U=1<<DIVb, UM=0.
- BUSY, update rule: when digit_valid && !stall, compute Cn={2'b11,C[W-1:2]}, K=Cn & ~(Cn<<1), K2=K<<1. Then U/UM update as follows:
  - +2: U=U|K2, UM=U|K
  - +1: U=U|K, UM=U
  - 0: U unchanged, UM=UM|K2|K
  - -1: U=UM|K2|K, UM=UM|K2
  - -2: U=UM|K2, UM=UM|K
  - In all cases C=Cn and iter++.
- All right-hand sides use the pre-update U/UM.
- Latency: each update is visible on the outputs the cycle after acceptance. No combinational path from udigit to any output.
- BUSY, hold conditions: stall=1 or digit_valid=0 holds all registers.
- BUSY->DONE when the NITER-th digit is accepted.
- DONE: done=1 for exactly one cycle; U/UM/C/iter held. Then go to IDLE; outputs remain held until the next start.
- start outside IDLE is ignored. start and flush asserted together in IDLE: flush wins (stay IDLE, no load).
- flush in any state returns to IDLE next cycle; U/UM/C/iter keep their values, busy=0, done=0.
- stall in DONE has no effect.
- Arithmetic is modulo 2^W; no overflow detection.

Optional Feature:
FDIVSQRT_OTFC_CHECK_EN:
- Defined: an accepted udigit with more than one bit set sets digit_err (sticky until next start). The digit is still applied by priority bit3 > bit2 > bit1 > bit0.
- Undefined: same priority decoding; digit_err tied to 0 and no check logic is generated.

Test Plan:
Bench parameters: DIVb=8, NITER=4, W=12; C0=0xF00.
- Divide, digits +1,+2,0,-1 back-to-back -> after each: (U,UM)=(0x040,0x000),(0x060,0x050),(0x060,0x05C),(0x05F,0x05E); C ends 0xFFF; done pulses one cycle after 4th acceptance; iter=4.
- Divide, first digit -2 -> U=0xF80, UM=0xF40, C=0xFC0.
- Sqrt start, first digit 0 -> U=0x100, UM=0x0C0.
- Same sequence as the first scenario with stall=1 for 3 cycles after the 2nd digit, plus digit_valid gaps -> identical final values; done delayed by the stall/gap count.
- resetn low during 3rd iteration -> all outputs 0 asynchronously. flush mid-BUSY -> busy=0 next cycle, no done, later start reloads C=0xF00.
- With FDIVSQRT_OTFC_CHECK_EN, udigit=0110 -> treated as +1, digit_err=1 until next start. Without the macro, digit_err stays 0.
